// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, default address width.
package lsu_pkg;

  localparam int unsigned ADDR_W = 10;

  typedef enum logic [1:0] {
    SizeByte    = 2'b00,
    SizeHalf    = 2'b01,
    SizeWord    = 2'b10,
    SizeIllegal = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StData,
    StWrite
  } lsu_state_e;

  // True when the access cannot be served: bad size or address not size-aligned.
  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] lo);
    logic bad;
    unique case (size)
      SizeByte:    bad = 1'b0;
      SizeHalf:    bad = lo[0];
      SizeWord:    bad = (lo != 2'b00);
      SizeIllegal: bad = 1'b1;
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extraction/extension and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic [1:0]  lane,
  input  logic        is_signed,
  input  logic [31:0] read_data,
  input  logic [15:0] store_data,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = read_data[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    load_ext = read_data;
    merged   = read_data;
    unique case (size)
      SizeByte: begin
        load_ext = {{24{is_signed & byte_sel[7]}}, byte_sel};
        merged[{lane, 3'b000} +: 8] = store_data[7:0];
      end
      SizeHalf: begin
        load_ext = {{16{is_signed & half_sel[15]}}, half_sel};
        if (lane[1]) merged[31:16] = store_data;
        else         merged[15:0]  = store_data;
      end
      default: begin
        load_ext = read_data;
        merged   = read_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a registered-read word memory;
// sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int unsigned ADDR_W = lsu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] byte_addr,
  input  logic [31:0]       store_data,
  output logic              req_ready,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              store_done,
  output logic              addr_error,
  output logic              memwrite_enable,
  output logic              memread_enable,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data
);

  import lsu_pkg::*;

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lane_q, lane_d;
  lsu_size_e         size_q, size_d;
  logic              signed_q, signed_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              store_done_q, store_done_d;
  logic              addr_error_q, addr_error_d;

  logic [31:0] load_ext;
  logic [31:0] merged;
  lsu_size_e   req_size_e;

  assign req_size_e = lsu_size_e'(req_size);

  lsu_lane_align u_lane_align (
    .size       (size_q),
    .lane       (lane_q),
    .is_signed  (signed_q),
    .read_data  (read_data),
    .store_data (wdata_q[15:0]),
    .load_ext   (load_ext),
    .merged     (merged)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lane_d       = lane_q;
    size_d       = size_q;
    signed_d     = signed_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    store_done_d = 1'b0;
    addr_error_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (lsu_misaligned(req_size_e, byte_addr[1:0])) begin
            addr_error_d = 1'b1;
          end else begin
            addr_d   = byte_addr[ADDR_W+1:2];
            lane_d   = byte_addr[1:0];
            size_d   = req_size_e;
            signed_d = req_signed;
            write_d  = req_write;
            wdata_d  = store_data;
            // Only a full-word store can skip the read of the old word.
            state_d  = (req_write && req_size_e == SizeWord) ? StWrite : StRead;
          end
        end
      end
      StRead: state_d = StData;
      StData: begin
        if (write_q) begin
          wdata_d = merged;
          state_d = StWrite;
        end else begin
          load_data_d  = load_ext;
          load_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      StWrite: begin
        store_done_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      lane_q       <= 2'b00;
      size_q       <= SizeByte;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      store_done_q <= store_done_d;
      addr_error_q <= addr_error_d;
    end
  end

  // Enables are gated by reset directly so a reset in WRITE cancels the write edge.
  assign memread_enable  = (state_q == StRead)  && !reset;
  assign memwrite_enable = (state_q == StWrite) && !reset;
  assign req_ready       = (state_q == StIdle);
  assign address         = addr_q;
  assign write_data      = wdata_q;
  assign load_valid      = load_valid_q;
  assign load_data       = load_data_q;
  assign store_done      = store_done_q;
  assign addr_error      = addr_error_q;

endmodule
